hier_fanin_collector: RTL
=========================

# hier_fanin_collector

Fan-in collector for generated module hierarchies, the upstream counterpart of the fan-out parent that instantiates child modules. It merges event/status words from up to 15 child instances into one upstream valid/ready stream. Fair round-robin arbitration selects among the children, each word is tagged with its source index, and the output is registered. A saturating event counter supports hierarchy-level checking.

## Interface
Parameters:
- NUM_CHILDREN, 15, number of child ports (2..16)
- DATA_W, 16, child payload width
- IDX_W, 4, source-index width (must be at least $clog2(NUM_CHILDREN))

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- child_valid  in  NUM_CHILDREN  bit i is high when child i presents a word
- child_data  in  NUM_CHILDREN*DATA_W  child i word in bits [i*DATA_W +: DATA_W]
- child_ready  out  NUM_CHILDREN  one-hot or zero; bit i high means child i's word is accepted this cycle
- up_valid  out  1  up_data holds a word
- up_ready  in  1  upstream accepts the word
- up_data  out  IDX_W+DATA_W  {source index, payload}
- event_count  out  16  words delivered upstream; saturates at 0xFFFF

## Operation
- Output slot: a single register, up_data plus up_valid. It has two states.
  - EMPTY: up_valid=0.
  - FULL: up_valid=1.
- load_en = !up_valid || up_ready. The slot can take a new word when it is empty, or when it is draining in the same cycle.
- Arbitration:
  - Among the set bits of child_valid, pick the first index at or after rr_ptr, wrapping modulo NUM_CHILDREN.
  - child_ready[grant] = load_en && |child_valid. All other bits are 0.
  - child_ready is combinational from child_valid, up_valid and up_ready. It never depends on child_data.
- On acceptance, with child_ready[g]=1 at an edge:
  - up_data <= {g, child_data[g]}, up_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_CHILDREN.
- Drain without refill: up_valid && up_ready && no child valid, then up_valid <= 0 and up_data holds its last value.
- Delivery is up_valid && up_ready at an edge. event_count increments by 1 on each delivery and holds at 0xFFFF.
- Transitions:
  - EMPTY to FULL on acceptance.
  - FULL to FULL on delivery with refill, or on stall (up_ready=0).
  - FULL to EMPTY on delivery without refill.
- Children must hold child_valid and child_data stable until accepted. Children that drop valid early are not handled specially; their word is simply not captured.
- Children indexed at or above NUM_CHILDREN do not exist, so they are never granted.

## Timing
- Reset (async assert, sync release):
  - up_valid=0, up_data=0, rr_ptr=0, event_count=0.
  - child_ready=0 while rst_n=0.
- Latency: a word accepted at edge N is visible on up_data/up_valid after edge N. The first possible delivery is at edge N+1.
- Throughput: 1 word/cycle while up_ready=1 and any child is valid. There are no bubbles between back-to-back words.
- Stall: while up_valid=1 and up_ready=0, all child_ready=0 and up_data is stable.
- Fairness: with all children valid continuously and up_ready=1, grants go 0,1,...,14,0,... Any continuously valid child waits at most NUM_CHILDREN-1 grants.
- Simultaneous delivery and acceptance in one cycle: both occur. event_count increments and the slot refills without passing through EMPTY.
- Counter saturation: a delivery when event_count=0xFFFF leaves it at 0xFFFF. There is no wrap.
- Reset mid-operation: a word in the slot is discarded, up_valid falls immediately (async), and the grant order restarts at child 0.

## Test plan
- Reset: rst_n=0 with child_valid=all ones -> up_valid=0, child_ready=0, event_count=0. Release with up_ready=1 -> child 0 is granted first and up_data=0x0_<data0> one cycle later.
- Round-robin: all 15 children valid, child i data=0x1000+i, up_ready=1, 30 cycles -> up_data sequence {0,0x1000}..{14,0x100E}, repeated twice. No bubbles. event_count=30.
- Stall: slot FULL with {3,0xABCD}, up_ready=0 for 5 cycles -> data is stable and child_ready=0. Raise up_ready -> delivered once and event_count increments by exactly 1.
- Sparse/wrap: only children 2 and 13 valid, rr_ptr=14 -> grant 2, then 13, then 2. Indices 0/1/14 are never granted.
- Drain to empty: single word from child 7, then child_valid=0 -> up_valid is high for 1 cycle with up_ready=1, then returns to 0. event_count=1.
- Saturation and reset: force 65 540 deliveries -> event_count=0xFFFF. Assert rst_n mid-stall -> up_valid=0 asynchronously, and after release event_count=0.

Source files
------------

// File: rtl/hier_fanin_collector_if.sv
// rtl/hier_fanin_collector_if.sv - child fan-in and upstream stream bundle
// master: the collector; slave: the children plus upstream consumer.
interface hier_fanin_collector_if #(
   parameter int NUM_CHILDREN = 15,
   parameter int DATA_W       = 16,
   parameter int IDX_W        = 4
);
   logic [NUM_CHILDREN-1:0]        child_valid;
   logic [NUM_CHILDREN*DATA_W-1:0] child_data;
   logic [NUM_CHILDREN-1:0]        child_ready;
   logic                           up_valid;
   logic                           up_ready;
   logic [IDX_W+DATA_W-1:0]        up_data;
   logic [15:0]                    event_count;

   modport master (
      input  child_valid, child_data, up_ready,
      output child_ready, up_valid, up_data, event_count
   );

   modport slave (
      output child_valid, child_data, up_ready,
      input  child_ready, up_valid, up_data, event_count
   );
endinterface

// File: rtl/hier_fanin_collector.sv
// rtl/hier_fanin_collector.sv - round-robin fan-in of child words into one registered upstream slot
// Words are tagged {source index, payload}; a saturating counter tracks deliveries.
module hier_fanin_collector #(
   parameter int NUM_CHILDREN = 15,
   parameter int DATA_W       = 16,
   parameter int IDX_W        = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   hier_fanin_collector_if.master bus
);
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]              state;
   logic [IDX_W-1:0]        rr_ptr;
   logic [IDX_W-1:0]        grant;
   logic [IDX_W-1:0]        idx;
   logic                    found;
   logic                    load_en;
   logic                    accept;
   logic [IDX_W+DATA_W-1:0] slot;
   logic [15:0]             count;
   logic [DATA_W-1:0]       words [NUM_CHILDREN];

   for (genvar i = 0; i < NUM_CHILDREN; i++) begin : g_words
      assign words[i] = bus.child_data[i*DATA_W +: DATA_W];
   end

   // First valid child at or after rr_ptr, scanning with wrap.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_CHILDREN; k++) begin
         idx = IDX_W'((int'(rr_ptr) + k) % NUM_CHILDREN);
         if (!found && bus.child_valid[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

   assign load_en         = (state == EMPTY) || bus.up_ready;
   assign accept          = load_en && found && rst_n;
   assign bus.child_ready = accept ? (NUM_CHILDREN'(1) << grant) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         slot   <= '0;
         rr_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) begin
            state  <= FULL;
            slot   <= {grant, words[grant]};
            rr_ptr <= IDX_W'((int'(grant) + 1) % NUM_CHILDREN);
         end else if (bus.up_ready) begin
            // Drained with nothing to refill; payload keeps its last value.
            state <= EMPTY;
         end
         if ((state == FULL) && bus.up_ready && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
         end
      end
   end

   assign bus.up_valid    = (state == FULL);
   assign bus.up_data     = slot;
   assign bus.event_count = count;
endmodule
